// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: passes ordinary instructions through one register stage
// and expands load-multiple / store-multiple into one LW/SW micro-op per
// selected register, lowest register index first.
module lm_sm_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [15:0] instr_in,
    input  logic [15:0] PC_in,
    input  logic [15:0] PC_plus1_in,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic [15:0] PC_plus1_out,
    output logic        valid_out,
    output logic        uop_out,
    output logic        stall_out
);

    localparam logic [15:0] BUBBLE = 16'hF000;

    typedef enum logic {
        PASS   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  mask, mask_nxt;
    logic [2:0]  offset, offset_nxt;
    logic [2:0]  ra_q, ra_nxt;
    logic [3:0]  opc_q, opc_nxt;
    logic [15:0] pc_q, pc_nxt;
    logic [15:0] pc1_q, pc1_nxt;
    logic [15:0] instr_nxt, pc_out_nxt, pc1_out_nxt;
    logic        valid_nxt, uop_nxt;

    logic        is_lmsm;
    logic [7:0]  src_mask;
    logic [7:0]  mask_cleared;
    logic [2:0]  low_k;

    // Index of the lowest set bit; 0 when the mask is empty (never used then).
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) k = 3'(i);
        end
        return k;
    endfunction

    // Micro-op word: LW for LM, SW for SM, RA always the base register.
    function automatic logic [15:0] make_uop(input logic [3:0] opc, input logic [2:0] rk,
                                             input logic [2:0] ra, input logic [2:0] off);
        logic [3:0] op;
        op = (opc == 4'b0111) ? 4'b0101 : 4'b0100;
        return {op, rk, ra, 3'b000, off};
    endfunction

    // The FSM state is visible to fetch directly: stall means "expanding".
    assign stall_out = (state == EXPAND);

    assign is_lmsm      = (instr_in[15:13] == 3'b011);
    assign src_mask     = (state == PASS) ? instr_in[7:0] : mask;
    assign low_k        = lowest_bit(src_mask);
    assign mask_cleared = src_mask & (src_mask - 8'd1);

    // Next-state and next-output decode for one enabled edge.
    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        offset_nxt  = offset;
        ra_nxt      = ra_q;
        opc_nxt     = opc_q;
        pc_nxt      = pc_q;
        pc1_nxt     = pc1_q;
        instr_nxt   = instr_out;
        pc_out_nxt  = PC_out;
        pc1_out_nxt = PC_plus1_out;
        valid_nxt   = valid_out;
        uop_nxt     = uop_out;

        if (state == EXPAND) begin
            // instr_in is ignored here; fetch is holding the next instruction.
            instr_nxt   = make_uop(opc_q, low_k, ra_q, offset);
            pc_out_nxt  = pc_q;
            pc1_out_nxt = pc1_q;
            valid_nxt   = 1'b1;
            uop_nxt     = 1'b1;
            mask_nxt    = mask_cleared;
            offset_nxt  = offset + 3'd1;
            state_nxt   = (mask_cleared != 8'd0) ? EXPAND : PASS;
        end else if (!valid_in || (is_lmsm && instr_in[7:0] == 8'd0)) begin
            // Empty slot, or an LM/SM that names no registers.
            instr_nxt = BUBBLE;
            valid_nxt = 1'b0;
            uop_nxt   = 1'b0;
        end else if (!is_lmsm) begin
            instr_nxt   = instr_in;
            pc_out_nxt  = PC_in;
            pc1_out_nxt = PC_plus1_in;
            valid_nxt   = 1'b1;
            uop_nxt     = 1'b0;
        end else begin
            // First micro-op leaves on the capture edge; the rest follow in EXPAND.
            instr_nxt   = make_uop(instr_in[15:12], low_k, instr_in[11:9], 3'd0);
            pc_out_nxt  = PC_in;
            pc1_out_nxt = PC_plus1_in;
            valid_nxt   = 1'b1;
            uop_nxt     = 1'b1;
            ra_nxt      = instr_in[11:9];
            opc_nxt     = instr_in[15:12];
            pc_nxt      = PC_in;
            pc1_nxt     = PC_plus1_in;
            mask_nxt    = mask_cleared;
            offset_nxt  = 3'd1;
            state_nxt   = (mask_cleared != 8'd0) ? EXPAND : PASS;
        end
    end

    // State register: reset beats flush, flush beats the enable freeze.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= PASS;
            mask         <= 8'd0;
            offset       <= 3'd0;
            ra_q         <= 3'd0;
            opc_q        <= 4'd0;
            pc_q         <= 16'd0;
            pc1_q        <= 16'd0;
            instr_out    <= BUBBLE;
            PC_out       <= 16'd0;
            PC_plus1_out <= 16'd0;
            valid_out    <= 1'b0;
            uop_out      <= 1'b0;
        end else if (flush) begin
            state     <= PASS;
            mask      <= 8'd0;
            offset    <= 3'd0;
            instr_out <= BUBBLE;
            valid_out <= 1'b0;
            uop_out   <= 1'b0;
        end else if (enable) begin
            state        <= state_nxt;
            mask         <= mask_nxt;
            offset       <= offset_nxt;
            ra_q         <= ra_nxt;
            opc_q        <= opc_nxt;
            pc_q         <= pc_nxt;
            pc1_q        <= pc1_nxt;
            instr_out    <= instr_nxt;
            PC_out       <= pc_out_nxt;
            PC_plus1_out <= pc1_out_nxt;
            valid_out    <= valid_nxt;
            uop_out      <= uop_nxt;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_lm_sm_sequencer;

    // Handshake: fetch presents instr_in/PC_in with valid_in; while stall_out
    // is 1 the sequencer ignores them and fetch holds the same instruction.

    logic        clock;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        valid_in;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic [15:0] pc_plus1_in;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1_out;
    logic        valid_out;
    logic        uop_out;
    logic        stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending micro-ops and expected output registers.
    logic [15:0] exp_q[$];
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic [15:0] m_pc1;
    logic        m_valid;
    logic        m_uop;

    lm_sm_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .valid_in     (valid_in),
        .instr_in     (instr_in),
        .PC_in        (pc_in),
        .PC_plus1_in  (pc_plus1_in),
        .instr_out    (instr_out),
        .PC_out       (pc_out),
        .PC_plus1_out (pc_plus1_out),
        .valid_out    (valid_out),
        .uop_out      (uop_out),
        .stall_out    (stall_out)
    );

    // Clock and reset-time defaults.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] exp_uop(input logic [3:0] op, input logic [2:0] rk,
                                            input logic [2:0] ra, input logic [2:0] off);
        return {op, rk, ra, 3'b000, off};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("instr_out", instr_out, m_instr);
        check_eq("pc_out", pc_out, m_pc);
        check_eq("pc_plus1_out", pc_plus1_out, m_pc1);
        check_eq("valid_out", {15'd0, valid_out}, {15'd0, m_valid});
        check_eq("uop_out", {15'd0, uop_out}, {15'd0, m_uop});
        check_eq("stall_out", {15'd0, stall_out}, {15'd0, exp_q.size() != 0});
    endtask

    task automatic model_bubble();
        m_instr = 16'hF000;
        m_valid = 1'b0;
        m_uop   = 1'b0;
    endtask

    // Model of one clock edge given the inputs about to be sampled.
    task automatic model_step(input logic r, input logic e, input logic f, input logic v,
                              input logic [15:0] ins, input logic [15:0] pc);
        logic [3:0] mop;
        int cnt;
        if (r) begin
            exp_q.delete();
            model_bubble();
            m_pc  = 16'd0;
            m_pc1 = 16'd0;
        end else if (f) begin
            exp_q.delete();
            model_bubble();
        end else if (e) begin
            if (exp_q.size() != 0) begin
                m_instr = exp_q.pop_front();
                m_valid = 1'b1;
                m_uop   = 1'b1;
            end else if (!v) begin
                model_bubble();
            end else if (ins[15:12] == 4'b0110 || ins[15:12] == 4'b0111) begin
                mop = (ins[15:12] == 4'b0111) ? 4'h5 : 4'h4;
                cnt = 0;
                for (int i = 0; i < 8; i++) begin
                    if (ins[i]) begin
                        exp_q.push_back(exp_uop(mop, 3'(i), ins[11:9], 3'(cnt)));
                        cnt++;
                    end
                end
                if (exp_q.size() == 0) begin
                    model_bubble();
                end else begin
                    m_instr = exp_q.pop_front();
                    m_pc    = pc;
                    m_pc1   = pc + 16'd1;
                    m_valid = 1'b1;
                    m_uop   = 1'b1;
                end
            end else begin
                m_instr = ins;
                m_pc    = pc;
                m_pc1   = pc + 16'd1;
                m_valid = 1'b1;
                m_uop   = 1'b0;
            end
        end
    endtask

    // Driver: apply inputs at the falling edge, let one rising edge pass,
    // then compare at the next falling edge.
    task automatic cycle(input logic r, input logic e, input logic f, input logic v,
                         input logic [15:0] ins, input logic [15:0] pc);
        reset       = r;
        enable      = e;
        flush       = f;
        valid_in    = v;
        instr_in    = ins;
        pc_in       = pc;
        pc_plus1_in = pc + 16'd1;
        model_step(r, e, f, v, ins, pc);
        @(negedge clock);
        check_outputs();
    endtask

    logic [15:0] cur_ins;
    logic [15:0] cur_pc;
    logic        cur_v;
    int          sel;

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; valid_in = 1'b0;
        instr_in = 16'h0000; pc_in = 16'h0000; pc_plus1_in = 16'h0001;
        m_instr = 16'h0000; m_pc = 16'h0000; m_pc1 = 16'h0000;
        m_valid = 1'b0; m_uop = 1'b0;

        // Reset values.
        cycle(1, 0, 0, 0, 16'h1234, 16'h0100);
        cycle(1, 1, 1, 1, 16'h1234, 16'h0100);
        check_eq("rst_instr", instr_out, 16'hF000);
        check_eq("rst_pc", pc_out, 16'h0000);
        check_eq("rst_valid", {15'd0, valid_out}, 16'd0);
        check_eq("rst_stall", {15'd0, stall_out}, 16'd0);

        // Plain ADD passes through in one cycle.
        cycle(0, 1, 0, 1, 16'h1298, 16'h0010);
        check_eq("add_instr", instr_out, 16'h1298);
        check_eq("add_pc", pc_out, 16'h0010);
        check_eq("add_pc1", pc_plus1_out, 16'h0011);
        check_eq("add_uop", {15'd0, uop_out}, 16'd0);

        // LM R5, {R0,R2,R5}; the following instruction is held and then taken.
        cycle(0, 1, 0, 1, 16'h6A25, 16'h0020);
        check_eq("lm_u0", instr_out, 16'h4140);
        check_eq("lm_u0_stall", {15'd0, stall_out}, 16'd1);
        cycle(0, 1, 0, 1, 16'h2345, 16'h0021);
        check_eq("lm_u1", instr_out, 16'h4541);
        check_eq("lm_u1_stall", {15'd0, stall_out}, 16'd1);
        cycle(0, 1, 0, 1, 16'h2345, 16'h0021);
        check_eq("lm_u2", instr_out, 16'h4B42);
        check_eq("lm_u2_stall", {15'd0, stall_out}, 16'd0);
        check_eq("lm_u2_pc", pc_out, 16'h0020);
        cycle(0, 1, 0, 1, 16'h2345, 16'h0021);
        check_eq("lm_next", instr_out, 16'h2345);
        check_eq("lm_next_uop", {15'd0, uop_out}, 16'd0);

        // SM R1 with all eight registers.
        cycle(0, 1, 0, 1, 16'h72FF, 16'h0040);
        check_eq("sm_first", instr_out, 16'h5040);
        for (int k = 1; k < 8; k++) begin
            cycle(0, 1, 0, 1, 16'h0000, 16'h0041);
            check_eq("sm_uop", instr_out, exp_uop(4'h5, 3'(k), 3'd1, 3'(k)));
            check_eq("sm_pc", pc_out, 16'h0040);
        end
        check_eq("sm_last", instr_out, 16'h5E47);
        check_eq("sm_done_stall", {15'd0, stall_out}, 16'd0);

        // Freeze for three cycles mid-expansion, then resume at R1.
        cycle(0, 1, 0, 1, 16'h660F, 16'h0050);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 16'h660F, 16'h0050);
            check_eq("frz_instr", instr_out, exp_uop(4'h4, 3'd0, 3'd3, 3'd0));
            check_eq("frz_stall", {15'd0, stall_out}, 16'd1);
        end
        for (int k = 1; k < 4; k++) begin
            cycle(0, 1, 0, 1, 16'h660F, 16'h0050);
            check_eq("frz_resume", instr_out, exp_uop(4'h4, 3'(k), 3'd3, 3'(k)));
        end

        // Flush on the second micro-op of a four-register LM.
        cycle(0, 1, 0, 1, 16'h66F0, 16'h0060);
        check_eq("fl_u0", instr_out, exp_uop(4'h4, 3'd4, 3'd3, 3'd0));
        cycle(0, 1, 1, 1, 16'h66F0, 16'h0060);
        check_eq("fl_valid", {15'd0, valid_out}, 16'd0);
        check_eq("fl_stall", {15'd0, stall_out}, 16'd0);
        cycle(0, 1, 0, 0, 16'h66F0, 16'h0061);
        check_eq("fl_quiet", {15'd0, valid_out}, 16'd0);

        // LM naming no registers is a single bubble.
        cycle(0, 1, 0, 1, 16'h6A00, 16'h0070);
        check_eq("lm0_instr", instr_out, 16'hF000);
        check_eq("lm0_stall", {15'd0, stall_out}, 16'd0);

        // Reset in the middle of an SM expansion.
        cycle(0, 1, 0, 1, 16'h72FF, 16'h0080);
        cycle(0, 1, 0, 1, 16'h72FF, 16'h0080);
        cycle(1, 1, 0, 1, 16'h72FF, 16'h0080);
        check_eq("mrst_instr", instr_out, 16'hF000);
        check_eq("mrst_pc1", pc_plus1_out, 16'h0000);
        check_eq("mrst_uop", {15'd0, uop_out}, 16'd0);
        cycle(0, 1, 0, 0, 16'h0000, 16'h0000);
        check_eq("mrst_after", {15'd0, valid_out}, 16'd0);

        // Random traffic against the model.
        cur_ins = 16'h0000;
        cur_pc  = 16'h0200;
        cur_v   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0) begin
                cur_ins = 16'($urandom);
                sel = $urandom_range(0, 3);
                if (sel == 0) cur_ins[15:12] = 4'b0110;
                if (sel == 1) cur_ins[15:12] = 4'b0111;
                if ($urandom_range(0, 7) == 0) cur_ins[7:0] = 8'h00;
                cur_pc = 16'($urandom);
                cur_v  = ($urandom_range(0, 6) != 0);
            end
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 39) == 0, cur_v, cur_ins, cur_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port: enable  input  1  downstream advance; 0 freezes all state and outputs.
REQ-004 SHALL have port: flush  input  1  kill the in-flight instruction/sequence (branch redirect).
REQ-005 SHALL have port: valid_in  input  1  instr_in is a real instruction.
REQ-006 SHALL have port: instr_in  input  16  fetched instruction: opcode [15:12], RA [11:9], imm8 [7:0].
REQ-007 SHALL have ports: PC_in, PC_plus1_in  input  16 each  PC and PC+1 of instr_in.
REQ-008 SHALL have port: instr_out  output  16  registered (micro-)instruction to the decode/ID_RF boundary.
REQ-009 SHALL have ports: PC_out, PC_plus1_out  output  16 each  registered PC and PC+1 tags for instr_out.
REQ-010 SHALL have port: valid_out  output  1  instr_out is valid.
REQ-011 SHALL have port: uop_out  output  1  instr_out is an LM/SM-generated micro-op.
REQ-012 SHALL have port: stall_out  output  1  combinational, 1 iff state = EXPAND; fetch holds instr_in/PC_in while 1.

Function
REQ-013 SHALL implement two states: PASS and EXPAND, plus a registered 8-bit remaining-mask, a 3-bit offset counter, and latched RA, opcode and PC pair.
REQ-014 SHALL, when enable=0 and reset=0 and flush=0, hold every register unchanged.
REQ-015 SHALL, in PASS with enable=1: if valid_in=0, load valid_out=0, uop_out=0, instr_out=16'hF000.
REQ-016 SHALL, in PASS with enable=1, pass a non-LM/SM instruction (opcode not 0110/0111) through: instr_out<=instr_in, PC pair copied, valid_out<=1, uop_out<=0; latency 1 cycle.
REQ-017 SHALL treat LM as opcode 4'b0110 and SM as 4'b0111; imm8 bit i selects register Ri; registers are processed in ascending index order.
REQ-018 SHALL, in PASS on a valid LM/SM with imm8=0, emit a bubble (valid_out<=0, instr_out<=16'hF000) and remain in PASS.
REQ-019 SHALL, in PASS on a valid LM/SM with imm8!=0, emit the first micro-op for the lowest set bit k in the same capture edge, store mask=imm8 with bit k cleared, set offset to 1, and go to EXPAND iff the stored mask is non-zero, else stay in PASS.
REQ-020 SHALL form each micro-op as {op, Rk, RA, 3'b000, off[2:0]} with op=4'b0100 (LW) for LM and 4'b0101 (SW) for SM; off = number of micro-ops already emitted for this instruction (0 for the first).
REQ-021 SHALL tag every micro-op with the PC pair of the originating LM/SM, valid_out=1 and uop_out=1.
REQ-022 SHALL, in EXPAND with enable=1, emit the micro-op for the lowest set bit of mask, clear that bit, increment offset, and return to PASS on the edge that emits the last set bit.
REQ-023 SHALL ignore instr_in/valid_in while in EXPAND; the held instruction is captured on the first enabled PASS edge after expansion.
REQ-024 SHALL emit exactly popcount(imm8) micro-ops (1..8); offset wrap from 7 to 0 is never reached within a sequence.
REQ-025 SHALL use RA as the base for all micro-ops regardless of whether RA appears in imm8; no base snapshot is taken.
REQ-026 SHALL, on flush=1 (reset=0), regardless of enable: valid_out<=0, uop_out<=0, instr_out<=16'hF000, mask<=0, offset<=0, state<=PASS; the instruction on instr_in that cycle is discarded.

Reset
REQ-027 SHALL give reset priority over flush and enable.
REQ-028 SHALL on reset load: state=PASS, mask=0, offset=0, instr_out=16'hF000, PC_out=0, PC_plus1_out=0, valid_out=0, uop_out=0; stall_out thereby 0.
REQ-029 SHALL abandon any partial expansion when reset asserts mid-sequence, emitting no further micro-ops.
REQ-030 SHALL have every output reset-defined; no dependence on power-up initial values.

Verification
REQ-031 SHALL cover: ADD 16'h1298 at PC 16'h0010, enable=1 -> next cycle instr_out=16'h1298, PC_out=16'h0010, PC_plus1_out=16'h0011, valid_out=1, uop_out=0, stall_out=0.
REQ-032 SHALL cover: LM 16'h6A25 (RA=R5, imm8=0010_0101) -> three cycles of 16'h4140, 16'h4541, 16'h4B42, uop_out=1; stall_out=1 for the first two; then the held next instruction is emitted.
REQ-033 SHALL cover: SM 16'h72FF (RA=R1, imm8=8'hFF) -> eight micro-ops 16'h5040..16'h5E47, PC_out constant, then PASS.
REQ-034 SHALL cover: enable=0 for 3 cycles mid-expansion -> outputs, mask and offset frozen; resumes with the next register, no skip or duplicate.
REQ-035 SHALL cover: flush during the 2nd micro-op of a 4-register LM -> next cycle valid_out=0, stall_out=0, no further micro-ops; LM with imm8=0 -> single bubble.
REQ-036 SHALL cover: reset asserted mid-sequence -> next cycle all outputs equal the REQ-028 values.
